// File: rtl/load_store_unit.sv
// Load/store unit: captures one request, drives a single memory access held for
// WAIT_CYCLES+1 cycles, then presents a registered response until it is accepted.
module load_store_unit #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_addr,
    output logic [1:0]  resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [31:0] eff_addr;
    logic [1:0]  cap_fault;

    // 2'b10 illegal funct3 takes priority over 2'b01 misalignment.
    function automatic logic [1:0] classify(input logic is_store, input logic [2:0] f3,
                                            input logic [1:0] a);
        logic legal;
        if (is_store) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else          legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                              (f3 == 3'b100) || (f3 == 3'b101);
        if (!legal)                             return 2'b10;
        if ((f3[1:0] == 2'b01) && a[0])         return 2'b01;
        if ((f3 == 3'b010) && (a != 2'b00))     return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        fault_d     = fault_q;
        resp_data_d = resp_data_q;
        eff_addr    = req_base + req_offset;
        cap_fault   = classify(req_is_store, req_funct3, eff_addr[1:0]);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d  = req_is_store;
                    funct3_d    = req_funct3;
                    addr_d      = eff_addr;
                    wdata_d     = req_wdata;
                    rd_d        = req_rd;
                    fault_d     = cap_fault;
                    wait_d      = WAIT_INIT;
                    resp_data_d = 32'h0;
                    state_d     = (cap_fault != 2'b00) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wait_q == 4'd0) begin
                    resp_data_d = is_store_q ? 32'h0 : mem_read_data;
                    state_d     = S_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= 4'd0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rd_q        <= 5'd0;
            fault_q     <= 2'b00;
            resp_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            fault_q     <= fault_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Strobes decode purely from registered state so they fall with reset at once.
    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = (state_q == S_RESP);
    assign mem_read       = (state_q == S_ACCESS) && !is_store_q;
    assign mem_write      = (state_q == S_ACCESS) && is_store_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_funct3     = funct3_q;
    assign resp_data      = resp_data_q;
    assign resp_rd        = rd_q;
    assign resp_addr      = addr_q;
    assign resp_fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (WAIT_CYCLES 0 and 3), each with a
// small wait-state memory model that commits a store only on its final strobe cycle.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n          [2];
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic        req_is_store   [2];
    logic [2:0]  req_funct3     [2];
    logic [31:0] req_base       [2];
    logic [31:0] req_offset     [2];
    logic [31:0] req_wdata      [2];
    logic [4:0]  req_rd         [2];
    logic        resp_valid     [2];
    logic        resp_ready     [2];
    logic [31:0] resp_data      [2];
    logic [4:0]  resp_rd        [2];
    logic [31:0] resp_addr      [2];
    logic [1:0]  resp_fault     [2];
    logic        mem_read       [2];
    logic        mem_write      [2];
    logic [31:0] mem_address    [2];
    logic [31:0] mem_write_data [2];
    logic [2:0]  mem_funct3     [2];
    logic [31:0] mem_read_data  [2];

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          k;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic [1:0]  exp_fault;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [1:0] a,
                                                input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sh;
        r  = old;
        sh = 8 * int'(a);
        case (f3[1:0])
            2'b00:   r[sh +: 8] = wd[7:0];
            2'b01:   r[(a[1] ? 16 : 0) +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8 * int'(a) +: 8];
        h = w[(a[1] ? 16 : 0) +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : 3;
        logic [31:0] mem [0:255] = '{default: 32'h0};
        int wr_run = 0;

        load_store_unit #(.WAIT_CYCLES(WC)) dut (
            .clk           (clk),
            .rst_n         (rst_n[g]),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_is_store  (req_is_store[g]),
            .req_funct3    (req_funct3[g]),
            .req_base      (req_base[g]),
            .req_offset    (req_offset[g]),
            .req_wdata     (req_wdata[g]),
            .req_rd        (req_rd[g]),
            .resp_valid    (resp_valid[g]),
            .resp_ready    (resp_ready[g]),
            .resp_data     (resp_data[g]),
            .resp_rd       (resp_rd[g]),
            .resp_addr     (resp_addr[g]),
            .resp_fault    (resp_fault[g]),
            .mem_read      (mem_read[g]),
            .mem_write     (mem_write[g]),
            .mem_address   (mem_address[g]),
            .mem_write_data(mem_write_data[g]),
            .mem_funct3    (mem_funct3[g]),
            .mem_read_data (mem_read_data[g])
        );

        // Memory with wait states: the store lands on the edge ending its last strobe cycle.
        always @(posedge clk) begin
            if (mem_write[g]) begin
                if (wr_run == WC) begin
                    mem[mem_address[g][9:2]] <= store_merge(mem[mem_address[g][9:2]],
                        mem_address[g][1:0], mem_funct3[g], mem_write_data[g]);
                    wr_run <= 0;
                end else begin
                    wr_run <= wr_run + 1;
                end
            end else begin
                wr_run <= 0;
            end
        end

        assign mem_read_data[g] = load_ext(mem[mem_address[g][9:2]], mem_address[g][1:0],
                                           mem_funct3[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        int w;
        int lat;
        int rdc;
        int wrc;
        bit side_ok;
        bit hold_ok;
        exp_t e;
        exp_t seen;
        k = v.k;
        w = (k == 0) ? 0 : 3;
        @(negedge clk);
        check($sformatf("req_ready_idle rd%0d", v.rd), 32'(req_ready[k]), 32'd1);
        req_is_store[k] = v.st;
        req_funct3[k]   = v.f3;
        req_base[k]     = v.base;
        req_offset[k]   = v.off;
        req_wdata[k]    = v.wdata;
        req_rd[k]       = v.rd;
        req_valid[k]    = 1'b1;
        resp_ready[k]   = (v.hold == 0);
        e.data  = v.exp_data;
        e.addr  = v.base + v.off;
        e.rd    = v.rd;
        e.fault = v.exp_fault;
        sb.push_back(e);
        @(posedge clk);
        rdc = 0;
        wrc = 0;
        lat = 0;
        side_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Busy-phase garbage on the request port must be ignored.
                req_is_store[k] = ~v.st;
                req_funct3[k]   = ~v.f3;
                req_base[k]     = 32'h5555_0000;
                req_offset[k]   = 32'h0000_0333;
                req_wdata[k]    = ~v.wdata;
                req_rd[k]       = ~v.rd;
            end
            if (mem_read[k]) rdc++;
            if (mem_write[k]) wrc++;
            if (mem_read[k] && mem_write[k]) side_ok = 1'b0;
            if (mem_read[k] || mem_write[k]) begin
                if (mem_address[k] !== e.addr || mem_funct3[k] !== v.f3) side_ok = 1'b0;
                if (v.st && mem_write_data[k] !== v.wdata) side_ok = 1'b0;
            end
            if (resp_valid[k]) begin
                lat = c;
                break;
            end
        end
        req_valid[k] = 1'b0;
        check($sformatf("latency rd%0d", v.rd), 32'(lat),
              32'((v.exp_fault != 2'b00) ? 1 : w + 2));
        check($sformatf("mem_read_cycles rd%0d", v.rd), 32'(rdc),
              32'((!v.st && v.exp_fault == 2'b00) ? w + 1 : 0));
        check($sformatf("mem_write_cycles rd%0d", v.rd), 32'(wrc),
              32'((v.st && v.exp_fault == 2'b00) ? w + 1 : 0));
        check($sformatf("mem_side rd%0d", v.rd), 32'(side_ok), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        check($sformatf("resp_rd rd%0d", v.rd), 32'(resp_rd[k]), 32'(e.rd));
        check($sformatf("resp_addr rd%0d", v.rd), resp_addr[k], e.addr);
        check($sformatf("resp_fault rd%0d", v.rd), 32'(resp_fault[k]), 32'(e.fault));
        if (e.fault == 2'b00)
            check($sformatf("resp_data rd%0d", v.rd), resp_data[k], e.data);
        seen.data  = resp_data[k];
        seen.addr  = resp_addr[k];
        seen.rd    = resp_rd[k];
        seen.fault = resp_fault[k];
        for (int h = 1; h <= v.hold; h++) begin
            @(negedge clk);
            hold_ok = (resp_valid[k] === 1'b1) && (req_ready[k] === 1'b0) &&
                      (resp_data[k] === seen.data) && (resp_addr[k] === seen.addr) &&
                      (resp_rd[k] === seen.rd) && (resp_fault[k] === seen.fault) &&
                      (mem_read[k] === 1'b0) && (mem_write[k] === 1'b0);
            check($sformatf("resp_hold rd%0d cyc%0d", v.rd, h), 32'(hold_ok), 32'd1);
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        bit quiet;
        for (int k = 0; k < 2; k++) begin
            rst_n[k]        = 1'b0;
            req_valid[k]    = 1'b0;
            req_is_store[k] = 1'b0;
            req_funct3[k]   = 3'b000;
            req_base[k]     = 32'h0;
            req_offset[k]   = 32'h0;
            req_wdata[k]    = 32'h0;
            req_rd[k]       = 5'd0;
            resp_ready[k]   = 1'b1;
        end

        //  k st  f3      base          off    wdata         rd  exp_data      fault  hold
        tbl.push_back('{0, 1'b1, 3'b010, 32'h0000_0100, 32'h4, 32'hDEAD_BEEF, 5'd1,  32'h0,         2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0,         5'd2,  32'hDEAD_BEEF, 2'b00, 0});
        tbl.push_back('{0, 1'b1, 3'b010, 32'h0000_0104, 32'h0, 32'h0000_80FF, 5'd3,  32'h0,         2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b000, 32'h0000_0105, 32'h0, 32'h0,         5'd7,  32'hFFFF_FF80, 2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b100, 32'h0000_0105, 32'h0, 32'h0,         5'd8,  32'h0000_0080, 2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b001, 32'h0000_0104, 32'h0, 32'h0,         5'd9,  32'hFFFF_80FF, 2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b101, 32'h0000_0104, 32'h0, 32'h0,         5'd10, 32'h0000_80FF, 2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0,         5'd11, 32'h0,         2'b01, 0});
        tbl.push_back('{0, 1'b1, 3'b011, 32'h0000_0104, 32'h0, 32'h1234_5678, 5'd12, 32'h0,         2'b10, 0});
        tbl.push_back('{0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0,         5'd13, 32'h0,         2'b00, 0});
        tbl.push_back('{0, 1'b1, 3'b000, 32'h0000_0107, 32'h0, 32'h1234_5678, 5'd14, 32'h0,         2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0,         5'd15, 32'h7800_80FF, 2'b00, 0});
        tbl.push_back('{0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 32'h0000_0001, 5'd16, 32'h0,         2'b01, 0});
        tbl.push_back('{0, 1'b0, 3'b110, 32'h0000_0104, 32'h0, 32'h0,         5'd17, 32'h0,         2'b10, 0});
        tbl.push_back('{0, 1'b1, 3'b001, 32'h0000_0106, 32'h0, 32'hAAAA_BEEF, 5'd18, 32'h0,         2'b00, 0});
        tbl.push_back('{0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h0,         5'd19, 32'hBEEF_80FF, 2'b00, 1});
        tbl.push_back('{0, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'h0,         5'd20, 32'h0,         2'b01, 0});
        tbl.push_back('{0, 1'b1, 3'b010, 32'h0000_0106, 32'h0, 32'h0,         5'd24, 32'h0,         2'b01, 0});
        tbl.push_back('{1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h1234_C001, 5'd21, 32'h0,         2'b00, 0});
        tbl.push_back('{1, 1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h0,         5'd22, 32'hFFFF_C001, 2'b00, 3});
        tbl.push_back('{1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0,         5'd23, 32'h0,         2'b00, 0});

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_resp_valid%0d", k), 32'(resp_valid[k]), 32'd0);
            check($sformatf("reset_mem_strobes%0d", k), {30'h0, mem_read[k], mem_write[k]}, 32'd0);
            check($sformatf("reset_mem_address%0d", k), mem_address[k], 32'h0);
            check($sformatf("reset_resp_data%0d", k), resp_data[k], 32'h0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        check("req_ready_after_reset0", 32'(req_ready[0]), 32'd1);
        check("req_ready_after_reset1", 32'(req_ready[1]), 32'd1);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Store abandoned by reset during its second access cycle.
        @(negedge clk);
        req_is_store[1] = 1'b1;
        req_funct3[1]   = 3'b010;
        req_base[1]     = 32'h0000_0040;
        req_offset[1]   = 32'h0;
        req_wdata[1]    = 32'hCAFE_F00D;
        req_rd[1]       = 5'd25;
        req_valid[1]    = 1'b1;
        resp_ready[1]   = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("abort_write_first_cycle", 32'(mem_write[1]), 32'd1);
        @(posedge clk);
        #2;
        rst_n[1] = 1'b0;
        #1;
        check("abort_write_dropped", 32'(mem_write[1]), 32'd0);
        check("abort_mem_address_cleared", mem_address[1], 32'h0);
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid[1] !== 1'b0 || mem_write[1] !== 1'b0) quiet = 1'b0;
        end
        rst_n[1] = 1'b1;
        #1;
        check("abort_quiet_in_reset", 32'(quiet), 32'd1);
        check("abort_req_ready_after_release", 32'(req_ready[1]), 32'd1);
        run_vec('{1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 5'd26, 32'h0, 2'b00, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
